// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one 32-bit transfer in flight, one PSEL per slot.
// Define AHB2APB_PSLVERR_EN to return PSLVERR as a two-cycle AHB ERROR response.
module ahb_to_apb_bridge #(
  parameter int  APB_ADDR_WIDTH = 12,
  parameter int  SLV_IDX_W      = 2,
  localparam int NUM_SLAVES     = 2**SLV_IDX_W
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [31:0]                HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [31:0]                HRDATA,
  output logic [APB_ADDR_WIDTH-1:0]  PADDR,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY,
  input  logic [NUM_SLAVES-1:0]      PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3
`ifdef AHB2APB_PSLVERR_EN
    , ST_ERR1 = 3'd4,
    ST_ERR2   = 3'd5
`endif
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [SLV_IDX_W-1:0]  idx_r;
  logic [SLV_IDX_W-1:0]  idx_s;
  logic                  open_s;
  logic                  accept_s;
  logic                  sel_ready_s;
  logic [31:0]           sel_rdata_s;
  logic [NUM_SLAVES-1:0] psel_s;
  logic                  hreadyout_s;
  logic                  capture_s;
  logic                  unused_s;

  // PWDATA is safe to pass through: the master holds HWDATA while HREADYOUT is low.
  assign PWDATA      = HWDATA;
  assign sel_ready_s = PREADY[idx_r];
  assign sel_rdata_s = PRDATA[32*idx_r +: 32];
  assign accept_s    = HSEL & HTRANS[1] & HREADY & HREADYOUT & open_s;
  assign capture_s   = (state_r == ST_ACCESS) && (state_s == ST_DONE) && !PWRITE;

  assign unused_s = ^{HSIZE, HTRANS[0], HADDR[31:APB_ADDR_WIDTH+SLV_IDX_W], HADDR[1:0]
`ifndef AHB2APB_PSLVERR_EN
                      , PSLVERR
`endif
                     };

  // States in which a new address phase may be accepted.
  always_comb begin
    open_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: open_s = 1'b1;
`ifdef AHB2APB_PSLVERR_EN
      ST_ERR2:          open_s = 1'b1;
`endif
      default:          open_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SETUP;
        else          state_s = ST_IDLE;
      end
      ST_SETUP: state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (!sel_ready_s) begin
          state_s = ST_ACCESS;
`ifdef AHB2APB_PSLVERR_EN
        end else if (PSLVERR[idx_r]) begin
          state_s = ST_ERR1;
`endif
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept_s) state_s = ST_SETUP;
        else          state_s = ST_IDLE;
      end
`ifdef AHB2APB_PSLVERR_EN
      ST_ERR1: state_s = ST_ERR2;
      ST_ERR2: begin
        if (accept_s) state_s = ST_SETUP;
        else          state_s = ST_IDLE;
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Slave index is latched on accept and held through the whole APB transfer.
  always_comb begin
    idx_s = idx_r;
    if (accept_s) idx_s = HADDR[APB_ADDR_WIDTH +: SLV_IDX_W];
    else          idx_s = idx_r;
  end

  // Output values for the coming cycle, decoded from the next state so outputs are registered.
  always_comb begin
    psel_s = {NUM_SLAVES{1'b0}};
    if ((state_s == ST_SETUP) || (state_s == ST_ACCESS)) psel_s[idx_s] = 1'b1;
    else                                                 psel_s = {NUM_SLAVES{1'b0}};
    case (state_s)
      ST_IDLE, ST_DONE: hreadyout_s = 1'b1;
`ifdef AHB2APB_PSLVERR_EN
      ST_ERR2:          hreadyout_s = 1'b1;
`endif
      default:          hreadyout_s = 1'b0;
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r   <= ST_IDLE;
      idx_r     <= {SLV_IDX_W{1'b0}};
      PADDR     <= {APB_ADDR_WIDTH{1'b0}};
      PWRITE    <= 1'b0;
      PSEL      <= {NUM_SLAVES{1'b0}};
      PENABLE   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRDATA    <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      PSEL      <= psel_s;
      PENABLE   <= (state_s == ST_ACCESS);
      HREADYOUT <= hreadyout_s;
      if (accept_s) begin
        PADDR  <= {HADDR[APB_ADDR_WIDTH-1:2], 2'b00};
        PWRITE <= HWRITE;
      end
      if (capture_s) HRDATA <= sel_rdata_s;
    end
  end

`ifdef AHB2APB_PSLVERR_EN
  // ERROR response is flagged in both cycles of the two-cycle AHB error sequence.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HRESP <= 1'b0;
    end else begin
      HRESP <= (state_s == ST_ERR1) || (state_s == ST_ERR2);
    end
  end
`else
  assign HRESP = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed, table-driven bench for ahb_to_apb_bridge; error expectations follow AHB2APB_PSLVERR_EN.
module tb_ahb_to_apb_bridge;

  logic         HCLK;
  logic         HRESETn;
  logic         HSEL;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic         HREADYOUT;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [11:0]  PADDR;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic [3:0]   PSLVERR;

`ifdef AHB2APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic        write;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    int          waits;
    logic [31:0] prdata;
    logic        err;
    logic [1:0]  idx;
    logic [3:0]  psel;
    logic [11:0] paddr;
    int          exp_low;
  } vec_t;

  typedef struct {
    logic       hsel;
    logic [1:0] htrans;
    logic       hready;
  } na_t;

  vec_t        vecs [7];
  na_t         nas  [4];
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_hrdata;

  ahb_to_apb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  function automatic logic [127:0] mk_prdata(input logic [1:0] idx, input logic [31:0] d);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = 32'hDEAD_0000 | 32'(i);
    r[32*int'(idx) +: 32] = d;
    return r;
  endfunction

  // One complete transfer, entered and (unless chained) left at a negedge in IDLE.
  task automatic xfer(input vec_t v, input bit chain);
    int low;
    low     = 0;
    HSEL    = 1'b1;
    HTRANS  = 2'b10;
    HWRITE  = v.write;
    HADDR   = v.haddr;
    HREADY  = 1'b1;
    HWDATA  = v.hwdata;
    PREADY  = ~v.psel;
    PSLVERR = ~v.psel;
    PRDATA  = mk_prdata(v.idx, v.prdata);
    step();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'hFFFF_FFFF;
    HWRITE = ~v.write;
    if (!HREADYOUT) low++;
    chk("setup_psel", 64'(PSEL), 64'(v.psel));
    chk("setup_penable", 64'(PENABLE), 64'(1'b0));
    chk("setup_paddr", 64'(PADDR), 64'(v.paddr));
    chk("setup_pwrite", 64'(PWRITE), 64'(v.write));
    if (v.write) chk("setup_pwdata", 64'(PWDATA), 64'(v.hwdata));
    for (int k = 0; k <= v.waits; k++) begin
      step();
      if (!HREADYOUT) low++;
      chk("access_psel", 64'(PSEL), 64'(v.psel));
      chk("access_penable", 64'(PENABLE), 64'(1'b1));
      chk("access_paddr", 64'(PADDR), 64'(v.paddr));
      if (k == v.waits) begin
        PREADY  = 4'hF;
        PSLVERR = v.err ? 4'hF : ~v.psel;
      end
    end
    step();
    PREADY  = 4'h0;
    PSLVERR = 4'h0;
    if (!v.write && !(ERR_EN && v.err)) exp_hrdata = v.prdata;
    if (ERR_EN && v.err) begin
      if (!HREADYOUT) low++;
      chk("err1_hreadyout", 64'(HREADYOUT), 64'(1'b0));
      chk("err1_hresp", 64'(HRESP), 64'(1'b1));
      step();
      chk("err2_hreadyout", 64'(HREADYOUT), 64'(1'b1));
      chk("err2_hresp", 64'(HRESP), 64'(1'b1));
    end else begin
      chk("done_hreadyout", 64'(HREADYOUT), 64'(1'b1));
      chk("done_hresp", 64'(HRESP), 64'(1'b0));
      chk("done_psel", 64'(PSEL), 64'(4'h0));
      chk("done_penable", 64'(PENABLE), 64'(1'b0));
    end
    chk("hrdata", 64'(HRDATA), 64'(exp_hrdata));
    chk("wait_states", 64'(low), 64'(v.exp_low));
    if (!chain) begin
      step();
      chk("idle_hreadyout", 64'(HREADYOUT), 64'(1'b1));
      chk("idle_hresp", 64'(HRESP), 64'(1'b0));
      chk("idle_psel", 64'(PSEL), 64'(4'h0));
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_hrdata = 32'h0000_0000;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'h0; HREADY = 1'b1;
    PRDATA = 128'h0; PREADY = 4'h0; PSLVERR = 4'h0;

    //            write  haddr          hwdata         waits prdata         err   idx   psel   paddr    low
    vecs[0] = '{1'b1, 32'h0000_1008, 32'hA5A5_0001, 0, 32'h0000_0000, 1'b0, 2'd1, 4'b0010, 12'h008, 2};
    vecs[1] = '{1'b0, 32'h0000_3010, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 2'd3, 4'b1000, 12'h010, 5};
    vecs[2] = '{1'b1, 32'h0000_0FFC, 32'h0F0F_F0F0, 1, 32'h0000_0000, 1'b0, 2'd0, 4'b0001, 12'hFFC, 3};
    vecs[3] = '{1'b0, 32'h0000_2ABE, 32'h0000_0000, 0, 32'hCAFE_BABE, 1'b0, 2'd2, 4'b0100, 12'hABC, 2};
    vecs[4] = '{1'b0, 32'hFFFF_7004, 32'h0000_0000, 0, 32'h0BAD_F00D, 1'b1, 2'd3, 4'b1000, 12'h004,
                ERR_EN ? 3 : 2};
    vecs[5] = '{1'b1, 32'h0000_1100, 32'h7777_1111, 0, 32'h0000_0000, 1'b0, 2'd1, 4'b0010, 12'h100, 2};
    vecs[6] = '{1'b0, 32'h0000_2200, 32'h0000_0000, 0, 32'h5555_AAAA, 1'b0, 2'd2, 4'b0100, 12'h200, 2};
    nas[0] = '{1'b0, 2'b10, 1'b1};
    nas[1] = '{1'b1, 2'b01, 1'b1};
    nas[2] = '{1'b1, 2'b00, 1'b1};
    nas[3] = '{1'b1, 2'b10, 1'b0};

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", 64'(HREADYOUT), 64'(1'b1));
    chk("rst_hresp", 64'(HRESP), 64'(1'b0));
    chk("rst_psel", 64'(PSEL), 64'(4'h0));
    chk("rst_penable", 64'(PENABLE), 64'(1'b0));
    chk("rst_hrdata", 64'(HRDATA), 64'(32'h0));
    chk("rst_paddr", 64'(PADDR), 64'(12'h0));
    chk("rst_pwrite", 64'(PWRITE), 64'(1'b0));
    HRESETn = 1'b1;
    step();

    // Address phases that must not start a transfer.
    for (int i = 0; i < 4; i++) begin
      HSEL = nas[i].hsel; HTRANS = nas[i].htrans; HREADY = nas[i].hready;
      HADDR = 32'h0000_1000; HWRITE = 1'b1;
      step();
      HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
      chk("noaccept_psel", 64'(PSEL), 64'(4'h0));
      chk("noaccept_hreadyout", 64'(HREADYOUT), 64'(1'b1));
      step();
    end

    for (int i = 0; i < 5; i++) xfer(vecs[i], 1'b0);

    // Back-to-back: the read is accepted in the DONE cycle of the write.
    xfer(vecs[5], 1'b1);
    xfer(vecs[6], 1'b0);

    // Reset asserted during ACCESS aborts the transfer.
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_1004; PREADY = 4'h0;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("mrst_setup_psel", 64'(PSEL), 64'(4'b0010));
    step();
    chk("mrst_access_penable", 64'(PENABLE), 64'(1'b1));
    HRESETn = 1'b0;
    PREADY  = 4'hF;
    step();
    chk("mrst_psel", 64'(PSEL), 64'(4'h0));
    chk("mrst_penable", 64'(PENABLE), 64'(1'b0));
    chk("mrst_hreadyout", 64'(HREADYOUT), 64'(1'b1));
    chk("mrst_hrdata", 64'(HRDATA), 64'(32'h0));
    chk("mrst_paddr", 64'(PADDR), 64'(12'h0));
    HRESETn = 1'b1;
    step();
    chk("mrst_after_psel", 64'(PSEL), 64'(4'h0));
    chk("mrst_after_penable", 64'(PENABLE), 64'(1'b0));
    PREADY = 4'h0;
    exp_hrdata = 32'h0000_0000;
    xfer(vecs[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
